// File: rtl/cube_pkg.sv
// Shared definitions for the cube display path: scheduler states, pixel field
// widths and the default screen geometry.
package cube_pkg;

  localparam int X_W          = 8;
  localparam int Y_W          = 7;
  localparam int COLOUR_W     = 3;
  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_START = 2'd2,
    ST_DRAW  = 2'd3
  } state_e;

endpackage

// File: rtl/clear_engine.sv
// Row-major full-screen sweep counter. Advances one pixel per cycle while go is
// high and wraps back to (0,0) after the last pixel so the next sweep starts clean.
module clear_engine
  import cube_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           go,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           first,
  output logic           last
);

  localparam logic [X_W-1:0] X_MAX = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(SCREEN_H - 1);

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (go) begin
      if (x_q == X_MAX) begin
        x_d = '0;
        y_d = (y_q == Y_MAX) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x     = x_q;
  assign y     = y_q;
  assign first = go && (x_q == '0) && (y_q == '0);
  assign last  = go && (x_q == X_MAX) && (y_q == Y_MAX);

endmodule

// File: rtl/redraw_scheduler.sv
// Owns the VGA pixel-write port: sequences power-up/full clears, drawer runs and
// coalesced redraw requests, and freezes face state while the drawer reads it.
module redraw_scheduler
  import cube_pkg::*;
#(
  parameter int                  SCREEN_W     = SCREEN_W_DEF,
  parameter int                  SCREEN_H     = SCREEN_H_DEF,
  parameter logic [COLOUR_W-1:0] BG_COLOUR    = 3'b000,
  parameter int                  DRAW_TIMEOUT = 65535
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                state_changed,
  input  logic                full_clear,
  output logic                drw_start,
  input  logic                drw_done,
  input  logic [X_W-1:0]      drw_x,
  input  logic [Y_W-1:0]      drw_y,
  input  logic [COLOUR_W-1:0] drw_colour,
  input  logic                drw_plot,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                freeze,
  output logic                busy,
  output logic                timeout
);

  localparam int             TO_W    = $clog2(DRAW_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(DRAW_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic                clr_pend_q, clr_pend_d;
  logic                red_pend_q, red_pend_d;
  logic                timeout_q, timeout_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic                plot_q, plot_d;

  logic                clr_go;
  logic [X_W-1:0]      ce_x;
  logic [Y_W-1:0]      ce_y;
  logic                ce_first;
  logic                ce_last;

  assign clr_go = (state_q == ST_CLEAR);

  clear_engine #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_clear_engine (
    .clk   (clk),
    .reset (reset),
    .go    (clr_go),
    .x     (ce_x),
    .y     (ce_y),
    .first (ce_first),
    .last  (ce_last)
  );

  // Drawer handshake: drw_start is a one-cycle pulse in START; the drawer answers
  // with a one-cycle drw_done, honoured only in DRAW. Pending flags are cleared in
  // the first cycle of the state that serves them, so a request landing in that
  // same cycle survives and earns another pass.
  always_comb begin
    state_d    = state_q;
    clr_pend_d = clr_pend_q | full_clear;
    red_pend_d = red_pend_q | state_changed | full_clear;
    timeout_d  = timeout_q;
    to_cnt_d   = '0;
    x_d        = x_q;
    y_d        = y_q;
    colour_d   = colour_q;
    plot_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr_pend_q || full_clear) begin
          state_d = ST_CLEAR;
        end else if (red_pend_q || state_changed) begin
          state_d = ST_START;
        end
      end
      ST_CLEAR: begin
        if (ce_first) begin
          clr_pend_d = full_clear;
        end
        plot_d   = 1'b1;
        x_d      = ce_x;
        y_d      = ce_y;
        colour_d = BG_COLOUR;
        if (ce_last) begin
          state_d    = ST_START;
          red_pend_d = 1'b1;
        end
      end
      ST_START: begin
        red_pend_d = state_changed | full_clear;
        state_d    = ST_DRAW;
      end
      ST_DRAW: begin
        plot_d   = drw_plot;
        x_d      = drw_x;
        y_d      = drw_y;
        colour_d = drw_colour;
        to_cnt_d = to_cnt_q + 1'b1;
        if (drw_done) begin
          state_d = ST_IDLE;
        end else if (to_cnt_q == TO_LAST) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      clr_pend_q <= 1'b1;
      red_pend_q <= 1'b1;
      timeout_q  <= 1'b0;
      to_cnt_q   <= '0;
      x_q        <= '0;
      y_q        <= '0;
      colour_q   <= '0;
      plot_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_pend_q <= clr_pend_d;
      red_pend_q <= red_pend_d;
      timeout_q  <= timeout_d;
      to_cnt_q   <= to_cnt_d;
      x_q        <= x_d;
      y_q        <= y_d;
      colour_q   <= colour_d;
      plot_q     <= plot_d;
    end
  end

  assign drw_start = (state_q == ST_START);
  assign freeze    = (state_q == ST_START) || (state_q == ST_DRAW);
  assign busy      = (state_q != ST_IDLE);
  assign timeout   = timeout_q;
  assign x         = x_q;
  assign y         = y_q;
  assign colour    = colour_q;
  assign plot      = plot_q;

endmodule

// File: tb/tb_redraw_scheduler.sv
// Directed bench for redraw_scheduler: power-up clear/draw, request coalescing,
// full clear with drawer pixels, reset mid-clear and the draw timeout.
module tb_redraw_scheduler;

  localparam int TB_TO = 300;

  logic       clk;
  logic       reset;
  logic       state_changed;
  logic       full_clear;
  logic       drw_start;
  logic       drw_done;
  logic [7:0] drw_x;
  logic [6:0] drw_y;
  logic [2:0] drw_colour;
  logic       drw_plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       freeze;
  logic       busy;
  logic       timeout;

  int vectors     = 0;
  int miscompares = 0;
  int start_cnt   = 0;
  int plot_cnt    = 0;

  redraw_scheduler #(
    .DRAW_TIMEOUT (TB_TO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .state_changed (state_changed),
    .full_clear    (full_clear),
    .drw_start     (drw_start),
    .drw_done      (drw_done),
    .drw_x         (drw_x),
    .drw_y         (drw_y),
    .drw_colour    (drw_colour),
    .drw_plot      (drw_plot),
    .x             (x),
    .y             (y),
    .colour        (colour),
    .plot          (plot),
    .freeze        (freeze),
    .busy          (busy),
    .timeout       (timeout)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (drw_start === 1'b1) start_cnt++;
    if (plot === 1'b1) plot_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drawer model: finish after k cycles, then expect IDLE with freeze dropped.
  task automatic run_draw(input int k);
    repeat (k) step();
    drw_done = 1'b1;
    step();
    drw_done = 1'b0;
    check("draw_done_busy", busy, 1'b0);
    check("draw_done_freeze", freeze, 1'b0);
  endtask

  // Called right after the edge that entered CLEAR; returns at the first DRAW cycle.
  task automatic check_clear(input string tag);
    int n = 0;
    int bad = 0;
    logic [7:0] ex = 8'd0;
    logic [6:0] ey = 7'd0;
    logic last_start = 1'b0;
    step();
    while (plot === 1'b1 && n < 20000) begin
      if (x !== ex || y !== ey || colour !== 3'b000) bad++;
      if (ex == 8'd159) begin
        ex = 8'd0;
        ey = ey + 7'd1;
      end else begin
        ex = ex + 8'd1;
      end
      last_start = drw_start;
      n++;
      step();
    end
    check({tag, "_pixels"}, n, 19200);
    check({tag, "_order"}, bad, 0);
    check({tag, "_start_on_last"}, last_start, 1'b1);
    check({tag, "_last_x"}, x, 8'd159);
    check({tag, "_last_y"}, y, 7'd119);
    check({tag, "_draw_freeze"}, freeze, 1'b1);
    check({tag, "_draw_start_low"}, drw_start, 1'b0);
  endtask

  // driver: directed sequence
  initial begin
    int s0;
    int p0;
    int n;
    reset = 1'b1;
    state_changed = 1'b0;
    full_clear = 1'b0;
    drw_done = 1'b0;
    drw_x = 8'd0;
    drw_y = 7'd0;
    drw_colour = 3'd0;
    drw_plot = 1'b0;
    repeat (3) step();
    check("rst_x", x, 8'd0);
    check("rst_y", y, 7'd0);
    check("rst_colour", colour, 3'd0);
    check("rst_plot", plot, 1'b0);
    check("rst_drw_start", drw_start, 1'b0);
    check("rst_freeze", freeze, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_timeout", timeout, 1'b0);

    // power-up clear then draw
    reset = 1'b0;
    step();
    check("pu_busy", busy, 1'b1);
    check("pu_plot0", plot, 1'b0);
    check_clear("pu_clear");
    run_draw(48);
    repeat (5) step();
    check("pu_idle", busy, 1'b0);
    check("pu_one_start", start_cnt, 1);

    // three state_changed pulses during DRAW coalesce into one extra pass
    s0 = start_cnt;
    p0 = plot_cnt;
    state_changed = 1'b1;
    step();
    state_changed = 1'b0;
    check("sc_start", drw_start, 1'b1);
    step();
    step(); state_changed = 1'b1; step(); state_changed = 1'b0;
    step(); state_changed = 1'b1; step(); state_changed = 1'b0;
    state_changed = 1'b1; step(); state_changed = 1'b0;
    check("sc_still_draw", freeze, 1'b1);
    run_draw(5);
    step();
    check("sc_second_start", drw_start, 1'b1);
    step();
    run_draw(3);
    repeat (5) step();
    check("sc_idle", busy, 1'b0);
    check("sc_two_starts", start_cnt - s0, 2);
    check("sc_no_clear", plot_cnt - p0, 0);

    // state_changed coincident with drw_start
    s0 = start_cnt;
    state_changed = 1'b1;
    step();
    check("co_start", drw_start, 1'b1);
    step();
    state_changed = 1'b0;
    check("co_draw_freeze", freeze, 1'b1);
    run_draw(4);
    step();
    check("co_restart_freeze", freeze, 1'b1);
    check("co_restart_start", drw_start, 1'b1);
    step();
    run_draw(4);
    repeat (3) step();
    check("co_idle", busy, 1'b0);
    check("co_two_starts", start_cnt - s0, 2);

    // full_clear with drawer pixel held; drawer strobes ignored outside DRAW
    drw_x = 8'd10;
    drw_y = 7'd20;
    drw_colour = 3'b101;
    drw_plot = 1'b1;
    drw_done = 1'b1;
    step();
    drw_done = 1'b0;
    check("fc_idle_plot_ignored", plot, 1'b0);
    check("fc_idle_done_ignored", busy, 1'b0);
    full_clear = 1'b1;
    step();
    full_clear = 1'b0;
    check("fc_busy", busy, 1'b1);
    check("fc_plot0", plot, 1'b0);
    check_clear("fc_clear");
    step();
    check("fc_drw_plot", plot, 1'b1);
    check("fc_drw_x", x, 8'd10);
    check("fc_drw_y", y, 7'd20);
    check("fc_drw_colour", colour, 3'b101);
    drw_plot = 1'b0;
    step();
    check("fc_drw_plot_off", plot, 1'b0);
    run_draw(3);
    repeat (3) step();
    check("fc_idle", busy, 1'b0);

    // reset at clear pixel 5000 (x=40, y=31)
    full_clear = 1'b1;
    step();
    full_clear = 1'b0;
    n = 0;
    while (!(plot === 1'b1 && x == 8'd40 && y == 7'd31) && n < 6000) begin
      step();
      n++;
    end
    check("mr_reached_px5000", n < 6000, 1'b1);
    reset = 1'b1;
    step();
    check("mr_plot", plot, 1'b0);
    check("mr_busy", busy, 1'b0);
    check("mr_x", x, 8'd0);
    check("mr_y", y, 7'd0);
    reset = 1'b0;
    step();
    check("mr_reclear_busy", busy, 1'b1);
    check_clear("mr_clear");

    // drawer never finishes: abort after TB_TO draw cycles
    check("to_before", timeout, 1'b0);
    n = 0;
    while (busy === 1'b1 && n < 2 * TB_TO) begin
      step();
      n++;
    end
    check("to_draw_cycles", n, TB_TO);
    check("to_flag", timeout, 1'b1);
    repeat (20) step();
    check("to_sticky", timeout, 1'b1);
    check("to_idle", busy, 1'b0);
    reset = 1'b1;
    step();
    check("to_reset_clears", timeout, 1'b0);
    reset = 1'b0;

    // report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/redraw_scheduler.md
# redraw_scheduler

Sequencing controller between the cube move logic, `cube_drawer` and `vga_adapter`. It owns the single VGA pixel-write port and decides when the drawer runs. It also runs a built-in full-screen clear, coalesces redraw requests that arrive while a draw or clear is in progress, and asserts `freeze` so face state stays stable for the whole draw.

## Interface
Parameters:
- `SCREEN_W`, 160, horizontal pixels; `x` range 0..159
- `SCREEN_H`, 120, vertical pixels; `y` range 0..119
- `BG_COLOUR`, 3'b000, colour written by the clear engine
- `DRAW_TIMEOUT`, 65535, maximum cycles spent in DRAW before abort

Ports:
- `clk`  in  1  system clock (CLOCK_50 domain)
- `reset`  in  1  synchronous, active-high reset
- `state_changed`  in  1  one-cycle pulse from move logic: cube state updated
- `full_clear`  in  1  one-cycle pulse: clear whole screen, then redraw
- `drw_start`  out  1  one-cycle start pulse to `cube_drawer`
- `drw_done`  in  1  one-cycle pulse from `cube_drawer`: draw finished
- `drw_x`  in  8  drawer pixel x
- `drw_y`  in  7  drawer pixel y
- `drw_colour`  in  3  drawer pixel colour
- `drw_plot`  in  1  drawer write strobe
- `x`  out  8  pixel x to `vga_adapter`
- `y`  out  7  pixel y to `vga_adapter`
- `colour`  out  3  pixel colour to `vga_adapter`
- `plot`  out  1  write strobe to `vga_adapter`
- `freeze`  out  1  high while the drawer reads faces; move logic must not update faces
- `busy`  out  1  high in any state other than IDLE
- `timeout`  out  1  sticky flag, set when a DRAW is aborted; cleared only by reset

## Operation
- Pending flags: `clr_pend` and `red_pend`.
  - `full_clear` sets both flags. `state_changed` sets `red_pend`.
  - Multiple pulses coalesce into one pending request.
- States:
  - IDLE: if `clr_pend`, go to CLEAR. Else if `red_pend`, go to START. Else stay.
  - CLEAR: clears `clr_pend` on entry. Writes `BG_COLOUR` to every pixel in row-major order (x fastest), one pixel per cycle. After pixel (159,119), go to START (`red_pend` forced to 1).
  - START: asserts `drw_start`, clears `red_pend`, then goes to DRAW.
  - DRAW: forwards drawer pixels. On `drw_done`, go to IDLE. If the DRAW cycle count reaches `DRAW_TIMEOUT`, set `timeout` and go to IDLE.
- A request pulse in the same cycle that its flag is being cleared wins: the flag stays set and a second pass follows.
- `drw_plot` is ignored outside DRAW. `drw_done` is ignored outside DRAW.
- `freeze` = state is START or DRAW.
- Clear counters: x counter 8 bits, y counter 7 bits. x wraps 159 to 0 and increments y. y never exceeds 119.

## Timing
- Reset values:
  - state IDLE, `clr_pend` = 1, `red_pend` = 1, so the power-up screen is cleared and drawn.
  - `x` = 0, `y` = 0, `colour` = 0, `plot` = 0, `drw_start` = 0, `freeze` = 0, `busy` = 0, `timeout` = 0.
- `x`, `y`, `colour` and `plot` are registered, one cycle latency.
  - In DRAW, `plot` at n+1 = `drw_plot` at n.
  - `plot` = 0 the cycle after leaving DRAW or CLEAR.
- `drw_start`, `freeze` and `busy` decode directly from the state register. There are no combinational input-to-output paths.
- Request pulse at cycle n in IDLE: state leaves IDLE at n+1.
- CLEAR lasts exactly 19200 cycles. `plot` is high for exactly 19200 consecutive cycles, from entry+1 through exit.
- `drw_start` is high for exactly 1 cycle. DRAW begins the following cycle.
- `drw_done` at cycle n: IDLE at n+1. `freeze` falls at n+1.
- Reset mid-CLEAR or mid-DRAW: IDLE next cycle, `plot` = 0, both flags set. The drawer shares the same reset and is inverted to `resetn` at top level.

## Structure
- Shared package `cube_pkg` holds:
  - state typedef (IDLE, CLEAR, START, DRAW)
  - `X_W` = 8, `Y_W` = 7, `COLOUR_W` = 3
  - `SCREEN_W`/`SCREEN_H` defaults
- Sub-module `clear_engine` contains the x/y sweep counter with `go`/`last` handshake. The scheduler keeps the FSM, pending flags, timeout counter and output mux.

## Test plan
- Release reset, drawer returns `drw_done` 50 cycles after `drw_start`: 19200 `plot` cycles with `colour` = 0 ending at (159,119), then one `drw_start`, then `busy` = 0.
- `state_changed` pulsed 3 times during DRAW: after `drw_done`, exactly one extra START/DRAW pass, no CLEAR.
- `state_changed` in the same cycle as `drw_start`: a second pass follows. `freeze` is continuous except for the 1-cycle IDLE between the passes.
- `full_clear` in IDLE: CLEAR covers all 19200 pixels, then a redraw. Drawer pixel (10,20,3'b101) with `drw_plot` = 1 appears on outputs one cycle later, only in DRAW.
- Drawer never asserts `drw_done`: after 65535 DRAW cycles, `timeout` = 1, state IDLE, `timeout` stays 1 until reset.
- Reset asserted at clear pixel 5000: `plot` = 0 next cycle, then a fresh full clear starting at (0,0).
